// File: rtl/mc_ctrl_fsm_pkg.sv
// Shared types and encodings for the multicycle RV32I controller.
// Holds the state enum, opcodes, select codes and the decode helper.
package mc_ctrl_fsm_pkg;

  typedef enum logic [3:0] {
    S_RESET,
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_LUI,
    S_ALUWB,
    S_JAL,
    S_JALR,
    S_LINK,
    S_BRANCH,
    S_TRAP
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_BLT = 3'b100;
  localparam logic [2:0] F3_BGE = 3'b101;

  // State that follows DECODE for a given opcode.
  function automatic state_t decode_next(
    input logic [6:0] op
  );
    state_t s;
    case (op)
      OP_LOAD:  s = S_MEMADR;
      OP_STORE: s = S_MEMADR;
      OP_R:     s = S_EXECR;
      OP_I:     s = S_EXECI;
      OP_BR:    s = S_BRANCH;
      OP_JAL:   s = S_JAL;
      OP_JALR:  s = S_JALR;
      OP_LUI:   s = S_LUI;
      default:  s = S_TRAP;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mc_ctrl_fsm_branch_cond.sv
// Branch condition evaluation from funct3 and ALU flags.
// Flags the funct3 encodings this core does not support.
module branch_cond
  import mc_ctrl_fsm_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       Zero,
  input  logic       Negative,
  output logic       taken,
  output logic       legal
);

  always_comb begin
    taken = 1'b0;
    legal = 1'b1;
    case (funct3)
      F3_BEQ: taken = Zero;
      F3_BNE: taken = ~Zero;
      F3_BLT: taken = Negative;
      F3_BGE: taken = ~Negative;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle controller: one state per cycle over a shared memory port.
// Also keeps the retired-instruction count and a sticky trap flag.
module mc_ctrl_fsm
  import mc_ctrl_fsm_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             Zero,
  input  logic             Negative,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             MemWrite,
  output logic             AdrSrc,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             RegWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic             instr_retired,
  output logic [CNT_W-1:0] instret,
  output logic             trap
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state;
  state_t           state_n;
  logic             taken;
  logic             legal;
  logic             retire;
  logic             trap_q;
  logic [CNT_W-1:0] cnt_q;

  branch_cond u_branch_cond (
    .funct3   (funct3),
    .Zero     (Zero),
    .Negative (Negative),
    .taken    (taken),
    .legal    (legal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_RESET;
      trap_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      state  <= state_n;
      trap_q <= trap_q | (state_n == S_TRAP);
      if (retire) cnt_q <= cnt_q + ONE;
    end
  end

  always_comb begin
    state_n   = state;
    mem_req   = 1'b0;
    MemWrite  = 1'b0;
    AdrSrc    = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RS2;
    ALUOp     = ALUOP_ADD;
    retire    = 1'b0;
    unique case (state)
      S_RESET: state_n = S_FETCH;
      S_FETCH: begin
        mem_req   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURES;
        if (mem_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_n = S_DECODE;
        end
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        state_n = decode_next(op);
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        state_n = (op == OP_LOAD) ? S_MEMREAD
                                  : S_MEMWRITE;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
        if (mem_ready) state_n = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = RES_RDATA;
        RegWrite  = 1'b1;
        retire    = 1'b1;
        state_n   = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req  = 1'b1;
        MemWrite = 1'b1;
        AdrSrc   = 1'b1;
        if (mem_ready) begin
          retire  = 1'b1;
          state_n = S_FETCH;
        end
      end
      S_EXECR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_RS2;
        ALUOp   = ALUOP_FUNCT;
        state_n = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALUOP_FUNCT;
        state_n = S_ALUWB;
      end
      S_LUI: begin
        ALUSrcA = SRCA_ZERO;
        ALUSrcB = SRCB_IMM;
        state_n = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        retire   = 1'b1;
        state_n  = S_FETCH;
      end
      // Target already sits in ALUOut; link value goes through ALUWB.
      S_JAL: begin
        PCWrite = 1'b1;
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_FOUR;
        state_n = S_ALUWB;
      end
      S_JALR: begin
        ALUSrcA   = SRCA_RS1;
        ALUSrcB   = SRCB_IMM;
        ResultSrc = RES_ALURES;
        PCWrite   = 1'b1;
        state_n   = S_LINK;
      end
      S_LINK: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_FOUR;
        state_n = S_ALUWB;
      end
      S_BRANCH: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_RS2;
        ALUOp   = ALUOP_SUB;
        if (legal) begin
          PCWrite = taken;
          retire  = 1'b1;
          state_n = S_FETCH;
        end else begin
          state_n = S_TRAP;
        end
      end
      S_TRAP: state_n = S_TRAP;
      default: state_n = S_TRAP;
    endcase
  end

  assign instr_retired = retire;
  assign instret       = cnt_q;
  assign trap          = trap_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Scoreboard bench for mc_ctrl_fsm: per-cycle expected control words
// are queued by the stimulus and compared by a negedge monitor.
module tb_mc_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] op = '0;
  logic [2:0] funct3 = '0;
  logic       Zero = 1'b0;
  logic       Negative = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, MemWrite, AdrSrc;
  logic       IRWrite, PCWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
  logic       instr_retired, trap;
  logic [3:0] instret;
  logic [15:0] act;

  mc_ctrl_fsm #(.CNT_W(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .op            (op),
    .funct3        (funct3),
    .Zero          (Zero),
    .Negative      (Negative),
    .mem_ready     (mem_ready),
    .mem_req       (mem_req),
    .MemWrite      (MemWrite),
    .AdrSrc        (AdrSrc),
    .IRWrite       (IRWrite),
    .PCWrite       (PCWrite),
    .RegWrite      (RegWrite),
    .ResultSrc     (ResultSrc),
    .ALUSrcA       (ALUSrcA),
    .ALUSrcB       (ALUSrcB),
    .ALUOp         (ALUOp),
    .instr_retired (instr_retired),
    .instret       (instret),
    .trap          (trap)
  );

  always #5 clk = ~clk;

  assign act = {mem_req, MemWrite, AdrSrc, IRWrite,
                PCWrite, RegWrite, ResultSrc, ALUSrcA,
                ALUSrcB, ALUOp, instr_retired, trap};

  function automatic logic [15:0] mk(
    input logic req, input logic mw, input logic adr,
    input logic ir, input logic pcw, input logic rw,
    input logic [1:0] rs, input logic [1:0] a,
    input logic [1:0] b, input logic [1:0] aop,
    input logic ret, input logic trp
  );
    return {req, mw, adr, ir, pcw, rw, rs, a, b, aop, ret, trp};
  endfunction

  // Hand-derived control word for each state/handshake case.
  localparam logic [15:0] W_RST   = 16'h0000;
  localparam logic [15:0] W_FWAIT =
    mk(1, 0, 0, 0, 0, 0, 2'd2, 2'd0, 2'd2, 2'd0, 0, 0);
  localparam logic [15:0] W_FGO   =
    mk(1, 0, 0, 1, 1, 0, 2'd2, 2'd0, 2'd2, 2'd0, 0, 0);
  localparam logic [15:0] W_DEC   =
    mk(0, 0, 0, 0, 0, 0, 2'd0, 2'd1, 2'd1, 2'd0, 0, 0);
  localparam logic [15:0] W_MADR  =
    mk(0, 0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 2'd0, 0, 0);
  localparam logic [15:0] W_MRD   =
    mk(1, 0, 1, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 0, 0);
  localparam logic [15:0] W_MWB   =
    mk(0, 0, 0, 0, 0, 1, 2'd1, 2'd0, 2'd0, 2'd0, 1, 0);
  localparam logic [15:0] W_MWWT  =
    mk(1, 1, 1, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 0, 0);
  localparam logic [15:0] W_MWGO  =
    mk(1, 1, 1, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 1, 0);
  localparam logic [15:0] W_EXR   =
    mk(0, 0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd0, 2'd2, 0, 0);
  localparam logic [15:0] W_EXI   =
    mk(0, 0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 2'd2, 0, 0);
  localparam logic [15:0] W_LUI   =
    mk(0, 0, 0, 0, 0, 0, 2'd0, 2'd3, 2'd1, 2'd0, 0, 0);
  localparam logic [15:0] W_AWB   =
    mk(0, 0, 0, 0, 0, 1, 2'd0, 2'd0, 2'd0, 2'd0, 1, 0);
  localparam logic [15:0] W_JAL   =
    mk(0, 0, 0, 0, 1, 0, 2'd0, 2'd1, 2'd2, 2'd0, 0, 0);
  localparam logic [15:0] W_JALR  =
    mk(0, 0, 0, 0, 1, 0, 2'd2, 2'd2, 2'd1, 2'd0, 0, 0);
  localparam logic [15:0] W_LINK  =
    mk(0, 0, 0, 0, 0, 0, 2'd0, 2'd1, 2'd2, 2'd0, 0, 0);
  localparam logic [15:0] W_BRT   =
    mk(0, 0, 0, 0, 1, 0, 2'd0, 2'd2, 2'd0, 2'd1, 1, 0);
  localparam logic [15:0] W_BRN   =
    mk(0, 0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd0, 2'd1, 1, 0);
  localparam logic [15:0] W_BRX   =
    mk(0, 0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd0, 2'd1, 0, 0);
  localparam logic [15:0] W_TRAP  = 16'h0001;

  typedef struct {
    logic [15:0] ctl;
    logic [3:0]  cnt;
    string       tag;
  } exp_t;

  exp_t       exp_q[$];
  logic [3:0] model_cnt = '0;
  int         checks = 0;
  int         failures = 0;

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (act !== e.ctl) begin
        failures++;
        $display("FAIL %s ctl act=%h exp=%h",
                 e.tag, act, e.ctl);
      end
      checks++;
      if (instret !== e.cnt) begin
        failures++;
        $display("FAIL %s instret act=%0d exp=%0d",
                 e.tag, instret, e.cnt);
      end
    end
  end

  task automatic cyc(input logic [15:0] w,
                     input logic rdy,
                     input string tag);
    exp_t e;
    mem_ready = rdy;
    e.ctl = w;
    e.cnt = model_cnt;
    e.tag = tag;
    exp_q.push_back(e);
    if (w[1]) model_cnt = model_cnt + 4'd1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_cnt = '0;
    cyc(W_RST, 1'b0, "rst0");
    cyc(W_RST, 1'b1, "rst1");
    rst_n = 1'b1;
    cyc(W_RST, 1'b1, "rst_rel");
  endtask

  task automatic branch(input logic [2:0] f3,
                        input logic z, input logic n,
                        input logic [15:0] wbr,
                        input string tag);
    op = 7'b1100011;
    funct3 = f3;
    Zero = z;
    Negative = n;
    cyc(W_FGO, 1'b1, {tag, "_f"});
    cyc(W_DEC, 1'b1, {tag, "_d"});
    cyc(wbr, 1'b1, {tag, "_br"});
  endtask

  initial begin
    @(posedge clk);
    #1;
    do_reset();

    op = 7'b0110011;
    cyc(W_FGO, 1'b1, "add_f");
    cyc(W_DEC, 1'b1, "add_d");
    cyc(W_EXR, 1'b1, "add_x");
    cyc(W_AWB, 1'b1, "add_wb");

    op = 7'b0000011;
    cyc(W_FWAIT, 1'b0, "lw_fw1");
    cyc(W_FWAIT, 1'b0, "lw_fw2");
    cyc(W_FGO, 1'b1, "lw_f");
    cyc(W_DEC, 1'b0, "lw_d");
    cyc(W_MADR, 1'b1, "lw_adr");
    cyc(W_MRD, 1'b0, "lw_mw1");
    cyc(W_MRD, 1'b0, "lw_mw2");
    cyc(W_MRD, 1'b0, "lw_mw3");
    cyc(W_MRD, 1'b1, "lw_mrd");
    cyc(W_MWB, 1'b0, "lw_wb");

    branch(3'b000, 1'b1, 1'b0, W_BRT, "beq_t");
    branch(3'b000, 1'b0, 1'b1, W_BRN, "beq_n");
    branch(3'b001, 1'b0, 1'b0, W_BRT, "bne_t");
    branch(3'b100, 1'b0, 1'b1, W_BRT, "blt_t");
    branch(3'b101, 1'b0, 1'b0, W_BRT, "bge_t");
    branch(3'b101, 1'b1, 1'b1, W_BRN, "bge_n");

    op = 7'b1100111;
    cyc(W_FGO, 1'b1, "jalr_f");
    cyc(W_DEC, 1'b1, "jalr_d");
    cyc(W_JALR, 1'b1, "jalr_j");
    cyc(W_LINK, 1'b1, "jalr_l");
    cyc(W_AWB, 1'b1, "jalr_wb");

    op = 7'b1101111;
    cyc(W_FGO, 1'b1, "jal_f");
    cyc(W_DEC, 1'b1, "jal_d");
    cyc(W_JAL, 1'b1, "jal_j");
    cyc(W_AWB, 1'b1, "jal_wb");

    op = 7'b0010011;
    cyc(W_FGO, 1'b1, "addi_f");
    cyc(W_DEC, 1'b1, "addi_d");
    cyc(W_EXI, 1'b1, "addi_x");
    cyc(W_AWB, 1'b1, "addi_wb");

    op = 7'b0110111;
    cyc(W_FGO, 1'b1, "lui_f");
    cyc(W_DEC, 1'b1, "lui_d");
    cyc(W_LUI, 1'b1, "lui_x");
    cyc(W_AWB, 1'b1, "lui_wb");

    op = 7'b0100011;
    cyc(W_FGO, 1'b1, "sw_f");
    cyc(W_DEC, 1'b1, "sw_d");
    cyc(W_MADR, 1'b1, "sw_adr");
    cyc(W_MWWT, 1'b0, "sw_wait");
    cyc(W_MWGO, 1'b1, "sw_go");

    op = 7'b0000000;
    cyc(W_FGO, 1'b1, "ill_f");
    cyc(W_DEC, 1'b1, "ill_d");
    for (int i = 0; i < 20; i++)
      cyc(W_TRAP, i[0], "ill_trap");
    do_reset();

    branch(3'b010, 1'b1, 1'b0, W_BRX, "bf3x");
    for (int i = 0; i < 3; i++)
      cyc(W_TRAP, 1'b1, "bf3x_trap");
    do_reset();

    op = 7'b0110011;
    cyc(W_FGO, 1'b1, "pre_f");
    cyc(W_DEC, 1'b1, "pre_d");
    cyc(W_EXR, 1'b1, "pre_x");
    cyc(W_AWB, 1'b1, "pre_wb");
    op = 7'b0100011;
    cyc(W_FGO, 1'b1, "swr_f");
    cyc(W_DEC, 1'b1, "swr_d");
    cyc(W_MADR, 1'b1, "swr_adr");
    cyc(W_MWWT, 1'b0, "swr_wait");
    do_reset();

    for (int i = 0; i < 16; i++)
      branch(3'b000, 1'b0, 1'b0, W_BRN, "wrap");
    op = 7'b0110011;
    cyc(W_FGO, 1'b1, "post_wrap_f");

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain left=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
Multicycle controller for the RV32I core variant with a single shared instruction/data memory port. It sequences the datapath one state per cycle: fetch, decode, address/execute, memory, writeback. It drives the mux selects, enables and ALUOp that the existing ALU decoder consumes, and performs a ready-based handshake with memory. It also keeps a retired-instruction counter and a sticky trap flag for illegal opcodes and branch funct3 values.

Parameters:
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
op  in  7  opcode from instruction register
funct3  in  3  funct3 from instruction register
Zero  in  1  ALU zero flag
Negative  in  1  ALU negative flag
mem_ready  in  1  memory completes the current request this cycle
mem_req  out  1  memory request valid
MemWrite  out  1  request is a write
AdrSrc  out  1  0=PC, 1=Result
IRWrite  out  1  load IR and OldPC
PCWrite  out  1  load PC from Result
RegWrite  out  1  register-file write enable
ResultSrc  out  2  00=ALUOut, 01=ReadData, 10=ALUResult
ALUSrcA  out  2  00=PC, 01=OldPC, 10=rs1, 11=zero
ALUSrcB  out  2  00=rs2, 01=Imm, 10=const 4
ALUOp  out  2  00=add, 01=compare(sub), 10=funct decode
instr_retired  out  1  one-cycle pulse on the final cycle of each instruction
instret  out  CNT_W  retired-instruction count
trap  out  1  sticky illegal-instruction flag

Behaviour:
- Reset is asynchronous: state=RESET, instret=0, trap=0. Every output is 0 in RESET. RESET moves to FETCH on the next edge. A reset mid-instruction abandons it, and mem_req drops at once because outputs decode combinationally from state.
- Outputs are Moore from state, except the ready-qualified strobes IRWrite/PCWrite in FETCH and the branch PCWrite.
- mem_ready is ignored when mem_req=0. A request is held, with constant AdrSrc/MemWrite, until mem_ready=1. Same-cycle completion is legal.
- FETCH: mem_req=1, AdrSrc=0, A=00, B=10, ALUOp=00, ResultSrc=10. When mem_ready=1: IRWrite=1, PCWrite=1, go to DECODE. Otherwise stay.
- DECODE: A=01, B=01, ALUOp=00 (branch/JAL target into ALUOut). Next state by op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 1100111 -> JALR
  - 0110111 -> LUI
  - anything else -> TRAP
- MEMADR: A=10, B=01, ALUOp=00. Go to MEMREAD if op=0000011, else MEMWRITE.
- MEMREAD: mem_req=1, AdrSrc=1, ResultSrc=00. On ready go to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, retire, go to FETCH.
- MEMWRITE: mem_req=1, MemWrite=1, AdrSrc=1, ResultSrc=00. On ready: retire, go to FETCH.
- EXECR: A=10, B=00, ALUOp=10, go to ALUWB.
- EXECI: A=10, B=01, ALUOp=10, go to ALUWB.
- LUI: A=11, B=01, ALUOp=00, go to ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, retire, go to FETCH.
- JAL: ResultSrc=00, PCWrite=1, A=01, B=10, ALUOp=00 (link value into ALUOut), go to ALUWB.
- JALR: A=10, B=01, ALUOp=00, ResultSrc=10, PCWrite=1, go to LINK.
- LINK: A=01, B=10, ALUOp=00, go to ALUWB.
- BRANCH: A=10, B=00, ALUOp=01, ResultSrc=00. Branch condition by funct3:
  - 000 taken=Zero
  - 001 taken=!Zero
  - 100 taken=Negative
  - 101 taken=!Negative
  - legal funct3: PCWrite=taken, retire, go to FETCH
  - other funct3: no PCWrite, go to TRAP
- TRAP: trap=1, all other outputs 0, no exit except reset.
- Cycle counts with zero-wait memory:
  - branch 3
  - R, I, LUI, store, JAL 4
  - load, JALR 5
- Each mem wait cycle adds 1 to the count.
- instret increments by 1 on each instr_retired and wraps modulo 2^CNT_W.

Decomposition:
- Shared package holds:
  - state enum
  - opcode constants: OP_LOAD, OP_STORE, OP_R, OP_I, OP_BR, OP_JAL, OP_JALR, OP_LUI
  - select encodings for ResultSrc, ALUSrcA, ALUSrcB, ALUOp
- One natural sub-module, branch_cond: inputs funct3, Zero, Negative; outputs taken, legal. Purely combinational.

Test Plan:
- add x3,x1,x2 (op=0110011), mem_ready tied 1 -> states FETCH, DECODE, EXECR, ALUWB. RegWrite high only in cycle 4. instr_retired pulses once. instret 0->1.
- lw (op=0000011), mem_ready low 2 cycles in FETCH and 3 in MEMREAD -> 10 cycles total. mem_req and AdrSrc held stable while waiting. IRWrite exactly once.
- beq funct3=000: Zero=1 -> PCWrite=1 in BRANCH. Zero=0 -> PCWrite=0. Both cases take 3 cycles. bge with Negative=0 -> taken.
- jalr -> PCWrite in JALR with ResultSrc=10. LINK uses A=01, B=10. RegWrite in ALUWB. Total 5 cycles.
- op=0000000, or branch funct3=010 -> enter TRAP, trap=1 and sticky for 20 cycles. rst_n low clears trap and instret.
- Assert rst_n low mid-MEMWRITE while mem_req=1 -> mem_req and MemWrite drop to 0 immediately. After release: RESET then FETCH. Preload instret to 2^CNT_W-1 and retire one instruction -> instret wraps to 0.
